// File: rtl/pong_game_controller_pkg.sv
// Shared pong definitions: FSM state codes and default tick lengths,
// used by the controller, renderer and collision logic.
package pong_game_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } game_state_t;

    localparam int DEF_SERVE_TICKS       = 60;
    localparam int DEF_POINT_TICKS       = 30;
    localparam int DEF_BEEP_PADDLE_TICKS = 4;
    localparam int DEF_BEEP_WALL_TICKS   = 12;

    // Bits needed to hold a down-counter loaded with (max(a, b) - 1).
    function automatic int tick_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pong_game_controller_beep_timer.sv
// Speaker timer: a collision event restarts a countdown, and beep stays
// high while the countdown is nonzero. Wall events outrank paddle events.
module pong_beep_timer
    import pong_game_controller_pkg::*;
#(
    parameter int PADDLE_TICKS = DEF_BEEP_PADDLE_TICKS,
    parameter int WALL_TICKS   = DEF_BEEP_WALL_TICKS
) (
    input  logic game_clk,
    input  logic reset,
    input  logic enable,
    input  logic paddle_col,
    input  logic wall_col,
    output logic beep,
    output logic beep_tone
);

    localparam int BW = $clog2(((PADDLE_TICKS > WALL_TICKS) ? PADDLE_TICKS : WALL_TICKS) + 1);

    logic [BW-1:0] beep_cnt;

    // Only the load is gated by enable; an active beep always finishes counting down.
    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            beep_cnt  <= '0;
            beep_tone <= 1'b0;
        end else if (enable && wall_col) begin
            beep_cnt  <= BW'(WALL_TICKS);
            beep_tone <= 1'b1;
        end else if (enable && paddle_col) begin
            beep_cnt  <= BW'(PADDLE_TICKS);
            beep_tone <= 1'b0;
        end else if (beep_cnt != '0) begin
            beep_cnt  <= beep_cnt - BW'(1);
        end
    end

    assign beep = (beep_cnt != '0);

endmodule

// File: rtl/pong_game_controller.sv
// Pong game sequencing FSM: idle, serve hold, play, point freeze and game over,
// plus start-button edge detection and the collision beep timer.
module pong_game_controller
    import pong_game_controller_pkg::*;
#(
    parameter int SERVE_TICKS       = DEF_SERVE_TICKS,
    parameter int POINT_TICKS       = DEF_POINT_TICKS,
    parameter int BEEP_PADDLE_TICKS = DEF_BEEP_PADDLE_TICKS,
    parameter int BEEP_WALL_TICKS   = DEF_BEEP_WALL_TICKS
) (
    input  logic       game_clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       paddle_col,
    input  logic       wall_col,
    input  logic       lossA,
    input  logic       lossB,
    output logic       ball_reset,
    output logic       ball_hold,
    output logic [2:0] game_state,
    output logic       winner_a,
    output logic       winner_b,
    output logic       beep,
    output logic       beep_tone
);

    localparam int CW = tick_width(SERVE_TICKS, POINT_TICKS);
    localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_TICKS - 1);
    localparam logic [CW-1:0] POINT_LOAD = CW'(POINT_TICKS - 1);

    game_state_t   state_q, state_d;
    logic [CW-1:0] tick_q, tick_d;
    logic          start_hist, hist_valid;
    logic          ball_reset_q, ball_reset_d;
    logic          win_a_q, win_a_d, win_b_q, win_b_d;
    logic          start, any_loss;

    // hist_valid blocks a button held through reset from counting as a press.
    assign start    = start_btn & ~start_hist & hist_valid;
    assign any_loss = lossA | lossB;

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            start_hist   <= 1'b0;
            hist_valid   <= 1'b0;
            ball_reset_q <= 1'b0;
            win_a_q      <= 1'b0;
            win_b_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            start_hist   <= start_btn;
            hist_valid   <= 1'b1;
            ball_reset_q <= ball_reset_d;
            win_a_q      <= win_a_d;
            win_b_q      <= win_b_d;
        end
    end

    // Winners are captured only on entry to game over; loss outranks a wall hit.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        ball_reset_d = 1'b0;
        win_a_d      = win_a_q;
        win_b_d      = win_b_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SERVE;
                    tick_d       = SERVE_LOAD;
                    ball_reset_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tick_q == '0) state_d = ST_PLAY;
                else              tick_d  = tick_q - CW'(1);
            end
            ST_PLAY: begin
                if (any_loss) begin
                    state_d = ST_GAMEOVER;
                    win_a_d = lossB;
                    win_b_d = lossA;
                end else if (wall_col) begin
                    state_d = ST_POINT;
                    tick_d  = POINT_LOAD;
                end
            end
            ST_POINT: begin
                if (any_loss) begin
                    state_d = ST_GAMEOVER;
                    win_a_d = lossB;
                    win_b_d = lossA;
                end else if (tick_q == '0) begin
                    state_d = ST_SERVE;
                    tick_d  = SERVE_LOAD;
                end else begin
                    tick_d  = tick_q - CW'(1);
                end
            end
            ST_GAMEOVER: begin
                if (start) begin
                    state_d      = ST_IDLE;
                    ball_reset_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ball_reset = ball_reset_q;
    assign ball_hold  = (state_q != ST_PLAY);
    assign game_state = state_q;
    assign winner_a   = win_a_q & (state_q == ST_GAMEOVER);
    assign winner_b   = win_b_q & (state_q == ST_GAMEOVER);

    pong_beep_timer #(
        .PADDLE_TICKS(BEEP_PADDLE_TICKS),
        .WALL_TICKS  (BEEP_WALL_TICKS)
    ) u_beep (
        .game_clk  (game_clk),
        .reset     (reset),
        .enable    ((state_q == ST_PLAY) || (state_q == ST_POINT)),
        .paddle_col(paddle_col),
        .wall_col  (wall_col),
        .beep      (beep),
        .beep_tone (beep_tone)
    );

endmodule

// File: tb/tb_pong_game_controller.sv
// Bench for pong_game_controller: directed scenarios with literal expectations,
// then randomized play checked every cycle against a phase/timestamp model.
module tb_pong_game_controller;

    localparam int SERVE_T = 60;
    localparam int POINT_T = 30;
    localparam int PAD_T   = 4;
    localparam int WALL_T  = 12;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_POINT = 3;
    localparam int S_OVER  = 4;

    logic       game_clk   = 1'b0;
    logic       reset      = 1'b0;
    logic       start_btn  = 1'b0;
    logic       paddle_col = 1'b0;
    logic       wall_col   = 1'b0;
    logic       lossA      = 1'b0;
    logic       lossB      = 1'b0;
    logic       ball_reset, ball_hold, winner_a, winner_b, beep, beep_tone;
    logic [2:0] game_state;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_on = 1'b0;

    // st: phase; age: cycles spent in the phase; prev: last sampled button (-1 = none since reset);
    // beep_end: first cycle index at which the beep is over.
    typedef struct {
        int st;
        int age;
        int prev;
        int ball_reset;
        int win_a;
        int win_b;
        int beep_end;
        int tone;
        int cyc;
    } model_t;

    model_t m;

    always #5 game_clk = ~game_clk;

    pong_game_controller #(
        .SERVE_TICKS      (SERVE_T),
        .POINT_TICKS      (POINT_T),
        .BEEP_PADDLE_TICKS(PAD_T),
        .BEEP_WALL_TICKS  (WALL_T)
    ) dut (
        .game_clk  (game_clk),
        .reset     (reset),
        .start_btn (start_btn),
        .paddle_col(paddle_col),
        .wall_col  (wall_col),
        .lossA     (lossA),
        .lossB     (lossB),
        .ball_reset(ball_reset),
        .ball_hold (ball_hold),
        .game_state(game_state),
        .winner_a  (winner_a),
        .winner_b  (winner_b),
        .beep      (beep),
        .beep_tone (beep_tone)
    );

    function automatic model_t model_reset();
        model_t r;
        r.st = S_IDLE; r.age = 0; r.prev = -1; r.ball_reset = 0;
        r.win_a = 0; r.win_b = 0; r.beep_end = 0; r.tone = 0; r.cyc = 0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t cur, input logic btn, input logic pad,
                                         input logic wall, input logic la, input logic lb);
        model_t n;
        bit     pressed;
        n = cur;
        n.cyc = cur.cyc + 1;
        n.ball_reset = 0;
        pressed = (btn == 1'b1) && (cur.prev == 0);
        if (cur.st == S_PLAY || cur.st == S_POINT) begin
            if (wall) begin
                n.beep_end = n.cyc + WALL_T;
                n.tone = 1;
            end else if (pad) begin
                n.beep_end = n.cyc + PAD_T;
                n.tone = 0;
            end
        end
        case (cur.st)
            S_IDLE: if (pressed) begin n.st = S_SERVE; n.age = 0; n.ball_reset = 1; end
            S_SERVE: begin
                n.age = cur.age + 1;
                if (n.age == SERVE_T) begin n.st = S_PLAY; n.age = 0; end
            end
            S_PLAY: begin
                if (la || lb) begin n.st = S_OVER; n.win_a = lb; n.win_b = la; end
                else if (wall) begin n.st = S_POINT; n.age = 0; end
            end
            S_POINT: begin
                if (la || lb) begin n.st = S_OVER; n.win_a = lb; n.win_b = la; end
                else begin
                    n.age = cur.age + 1;
                    if (n.age == POINT_T) begin n.st = S_SERVE; n.age = 0; end
                end
            end
            default: if (pressed) begin n.st = S_IDLE; n.ball_reset = 1; end
        endcase
        n.prev = btn;
        return n;
    endfunction

    always @(posedge game_clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, start_btn, paddle_col, wall_col, lossA, lossB);
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic apply_stimulus(input logic btn, input logic pad, input logic wall,
                                  input logic la, input logic lb, input logic rst);
        @(posedge game_clk);
        #2;
        start_btn  = btn;
        paddle_col = pad;
        wall_col   = wall;
        lossA      = la;
        lossB      = lb;
        reset      = rst;
    endtask

    always @(negedge game_clk) begin
        if (model_on) begin
            check_output("cyc_state",      int'(game_state), m.st);
            check_output("cyc_ball_hold",  int'(ball_hold),  (m.st != S_PLAY) ? 1 : 0);
            check_output("cyc_ball_reset", int'(ball_reset), m.ball_reset);
            check_output("cyc_winner_a",   int'(winner_a),   (m.st == S_OVER) ? m.win_a : 0);
            check_output("cyc_winner_b",   int'(winner_b),   (m.st == S_OVER) ? m.win_b : 0);
            check_output("cyc_beep",       int'(beep),       (m.cyc < m.beep_end) ? 1 : 0);
            check_output("cyc_beep_tone",  int'(beep_tone),  m.tone);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int   serve_len, point_len, beep_len, guard;
        logic r_btn, r_pad, r_wall, r_la, r_lb, r_rst;

        #1 reset = 1'b1;
        model_on = 1'b1;
        @(negedge game_clk);
        check_output("rst_state",      int'(game_state), 0);
        check_output("rst_ball_hold",  int'(ball_hold),  1);
        check_output("rst_ball_reset", int'(ball_reset), 0);
        check_output("rst_beep",       int'(beep),       0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);

        // Start, one-cycle ball_reset, 60-cycle serve hold, then play.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge game_clk);
        check_output("start_state",      int'(game_state), 1);
        check_output("start_ball_reset", int'(ball_reset), 1);
        @(negedge game_clk);
        check_output("ball_reset_single", int'(ball_reset), 0);
        serve_len = 1;
        while (game_state == 3'd1 && serve_len < 200) begin
            serve_len++;
            @(negedge game_clk);
        end
        check_output("serve_len",      serve_len, 60);
        check_output("play_state",     int'(game_state), 2);
        check_output("play_ball_hold", int'(ball_hold), 0);

        // Wall hit: point freeze of 30 cycles with a 12-cycle wall-tone beep.
        apply_stimulus(0, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge game_clk);
        check_output("wall_state", int'(game_state), 3);
        check_output("wall_tone",  int'(beep_tone), 1);
        point_len = 0;
        beep_len  = 0;
        while (game_state == 3'd3 && point_len < 200) begin
            point_len++;
            if (beep) beep_len++;
            @(negedge game_clk);
        end
        check_output("point_len",       point_len, 30);
        check_output("wall_beep_len",   beep_len,  12);
        check_output("point_to_serve",  int'(game_state), 1);
        guard = 0;
        while (game_state != 3'd2 && guard < 200) begin
            guard++;
            @(negedge game_clk);
        end
        check_output("serve_to_play", int'(game_state), 2);

        // Paddle hit: 4-cycle beep, then a second hit in beep cycle 2 restarts it.
        apply_stimulus(0, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge game_clk);
        beep_len = 0;
        while (beep && beep_len < 50) begin
            beep_len++;
            @(negedge game_clk);
        end
        check_output("paddle_beep_len",   beep_len, 4);
        check_output("paddle_tone",       int'(beep_tone), 0);
        check_output("paddle_stays_play", int'(game_state), 2);
        apply_stimulus(0, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge game_clk);
        beep_len = 0;
        while (beep && beep_len < 50) begin
            beep_len++;
            @(negedge game_clk);
        end
        check_output("paddle_restart_len", beep_len, 4);

        // Loss and wall together: game over with B winning, then start back to idle.
        apply_stimulus(0, 0, 1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0);
        @(negedge game_clk);
        check_output("over_state",    int'(game_state), 4);
        check_output("over_winner_a", int'(winner_a), 0);
        check_output("over_winner_b", int'(winner_b), 1);
        apply_stimulus(1, 0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge game_clk);
        check_output("over_to_idle",       int'(game_state), 0);
        check_output("over_ball_reset",    int'(ball_reset), 1);
        check_output("idle_winner_b",      int'(winner_b), 0);
        @(negedge game_clk);
        check_output("over_ball_reset_end", int'(ball_reset), 0);

        // Reset during serve with counter at 20 while start is held down.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        repeat (39) @(posedge game_clk);
        #1;
        check_output("serve_before_reset", int'(game_state), 1);
        #1 reset = 1'b1;
        #1;
        check_output("abort_state",     int'(game_state), 0);
        check_output("abort_ball_hold", int'(ball_hold), 1);
        check_output("abort_tone",      int'(beep_tone), 0);
        check_output("abort_beep",      int'(beep), 0);
        apply_stimulus(1, 0, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge game_clk);
            check_output("held_btn_no_start", int'(game_state), 0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge game_clk);
        check_output("repress_state",      int'(game_state), 1);
        check_output("repress_ball_reset", int'(ball_reset), 1);

        // Randomized play against the model.
        r_btn = 1'b0; r_la = 1'b0; r_lb = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) r_btn = ~r_btn;
            r_pad  = ($urandom_range(0, 5) == 0);
            r_wall = ($urandom_range(0, 9) == 0);
            r_la   = r_la ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 299) == 0);
            r_lb   = r_lb ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 299) == 0);
            r_rst  = ($urandom_range(0, 799) == 0);
            apply_stimulus(r_btn, r_pad, r_wall, r_la, r_lb, r_rst);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge game_clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
